// File: rtl/param_dpr.sv
`default_nettype none
// param_dpr: single-clock simple dual-port RAM with byte enables, 1/2-cycle read pipeline,
// collision policy and post-reset clear sequencer. Optional parity: PARAM_DPR_PARITY_EN.
module param_dpr #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int RD_LAT    = 1,
  parameter int COLL_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  rd_par_err
);

  localparam int              c_NB       = DATA_W / 8;
  localparam int              c_IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_IW-1:0] c_LAST     = c_IW'(DEPTH - 1);
  localparam logic [0:0]      c_ST_INIT  = 1'b0;
  localparam logic [0:0]      c_ST_READY = 1'b1;

  logic [0:0]        r_state;
  logic [c_IW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic              w_rd_in;
  logic              w_coll;
  logic [c_IW-1:0]   w_wa;
  logic [c_IW-1:0]   w_ra;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_rd_perr;

  // init_req wins over any same-cycle access
  assign w_ready   = (r_state == c_ST_READY) && !init_req;
  assign w_wa      = wr_addr[c_IW-1:0];
  assign w_ra      = rd_addr[c_IW-1:0];
  assign w_wr_ok   = w_ready && wr_en && ({1'b0, wr_addr} < c_DEPTH);
  assign w_rd_acc  = w_ready && rd_en;
  assign w_rd_in   = ({1'b0, rd_addr} < c_DEPTH);
  assign w_coll    = w_wr_ok && (wr_addr == rd_addr);
  assign init_busy = (r_state == c_ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (init_req) begin
            r_cnt <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= c_ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_READY: begin
          if (init_req) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= c_ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == c_ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < c_NB; i++) begin
        if (wr_be[i]) r_mem[w_wa][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read-old falls out of reading the array before the edge; write-through merges here
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) begin
      w_rd_word = r_mem[w_ra];
      if ((COLL_MODE == 1) && w_coll) begin
        for (int i = 0; i < c_NB; i++) begin
          if (wr_be[i]) w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef PARAM_DPR_PARITY_EN
  logic [c_NB-1:0] r_par_mem [DEPTH];
  logic [c_NB-1:0] w_par_rd;

  always_ff @(posedge clk) begin
    if (r_state == c_ST_INIT) begin
      r_par_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < c_NB; i++) begin
        if (wr_be[i]) r_par_mem[w_wa][i] <= ^wr_data[8*i +: 8];
      end
    end
  end

  // Bytes forwarded from the write port carry freshly computed parity, so they never flag
  always_comb begin
    w_rd_perr = 1'b0;
    w_par_rd  = '0;
    if (w_rd_in) begin
      w_par_rd = r_par_mem[w_ra];
      for (int i = 0; i < c_NB; i++) begin
        if (!((COLL_MODE == 1) && w_coll && wr_be[i]) &&
            ((^r_mem[w_ra][8*i +: 8]) != w_par_rd[i])) begin
          w_rd_perr = 1'b1;
        end
      end
    end
  end
`else
  assign w_rd_perr = 1'b0;
`endif

  logic              r_s1_valid;
  logic              r_s1_err;
  logic [DATA_W-1:0] r_s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      r_s1_err   <= w_rd_acc && w_rd_perr;
      if (w_rd_acc) r_s1_data <= w_rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic              r_s2_err;
      logic [DATA_W-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign rd_data    = r_s2_data;
      assign rd_valid   = r_s2_valid;
      assign rd_par_err = r_s2_err;
    end else begin : g_lat1
      assign rd_data    = r_s1_data;
      assign rd_valid   = r_s1_valid;
      assign rd_par_err = r_s1_err;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_dpr.sv
`default_nettype none
// Bench for param_dpr: two instances (RD_LAT=1/read-old, RD_LAT=2/write-through) on shared
// random and directed stimulus, checked by a queue scoreboard against a word-level array model.
module tb_param_dpr;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          init_req = 1'b0;
  logic          wr_en    = 1'b0;
  logic          rd_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [AW-1:0] rd_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic [1:0]    wr_be    = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, bsy0, bsy1, perr0, perr1;

  param_dpr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1), .COLL_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(bsy0), .rd_par_err(perr0));

  param_dpr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2), .COLL_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(bsy1), .rd_par_err(perr1));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t    q0[$];
  exp_t    q1[$];
  bit [DW-1:0] m_mem [2][DEP];
  bit [1:0]    m_cor [DEP];
  bit      m_busy   = 1'b1;
  int      m_cnt    = 0;
  bit      e_busy   = 1'b1;
  int      edge_cnt = 0;
  int      n_tests  = 0;
  int      n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [DW-1:0] d, input logic e);
    exp_t x;
    bit   have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) x = (k == 0) ? q0[0] : q1[0];
    if (v === 1'b1) begin
      if (!have) begin
        chk($sformatf("dut%0d_unexpected_rd_valid", k), {31'd0, v}, 32'd0);
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("dut%0d_rd_data", k), {16'd0, d}, {16'd0, x.data});
        chk($sformatf("dut%0d_rd_par_err", k), {31'd0, e}, {31'd0, x.err});
        chk($sformatf("dut%0d_latency_edge", k), edge_cnt, x.due);
      end
    end else begin
      chk($sformatf("dut%0d_par_err_idle", k), {31'd0, e}, 32'd0);
      if (have && x.due <= edge_cnt) begin
        chk($sformatf("dut%0d_rd_valid_missing", k), {31'd0, v}, 32'd1);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    chk("dut0_init_busy", {31'd0, bsy0}, {31'd0, e_busy});
    chk("dut1_init_busy", {31'd0, bsy1}, {31'd0, e_busy});
    mon(0, rd_valid0, rd_data0, perr0);
    mon(1, rd_valid1, rd_data1, perr1);
  end

  // Expected result of a read accepted at the coming edge; k=1 is the write-through instance
  function automatic exp_t mk(input int k);
    exp_t     x;
    int       a;
    bit [1:0] c;
    a      = int'(rd_addr);
    x.data = '0;
    x.err  = 1'b0;
    x.due  = edge_cnt + 1 + k;
    if (a < DEP) begin
      x.data = m_mem[k][a];
      c      = m_cor[a];
      if (k == 1 && wr_en && wr_addr == rd_addr) begin
        for (int b = 0; b < 2; b++) begin
          if (wr_be[b]) x.data[8*b +: 8] = wr_data[8*b +: 8];
        end
        c = c & ~wr_be;
      end
      x.err = |c;
    end
    return x;
  endfunction

  task automatic step();
    int wa;
    wa = int'(wr_addr);
    if (rst_n) begin
      if (m_busy) begin
        m_mem[0][m_cnt] = '0;
        m_mem[1][m_cnt] = '0;
        m_cor[m_cnt]    = '0;
        if (init_req) m_cnt = 0;
        else if (m_cnt == DEP - 1) m_busy = 1'b0;
        else m_cnt++;
      end else if (init_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end else begin
        if (rd_en) begin
          q0.push_back(mk(0));
          q1.push_back(mk(1));
        end
        if (wr_en && wa < DEP) begin
          for (int b = 0; b < 2; b++) begin
            if (wr_be[b]) begin
              m_mem[0][wa][8*b +: 8] = wr_data[8*b +: 8];
              m_mem[1][wa][8*b +: 8] = wr_data[8*b +: 8];
              m_cor[wa][b]           = 1'b0;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    e_busy = m_busy;
  endtask

  task automatic set_in(input bit we, input int wa, input int wd, input int be,
                        input bit re, input int ra, input bit ir);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = DW'(wd);
    wr_be    = 2'(be);
    rd_en    = re;
    rd_addr  = AW'(ra);
    init_req = ir;
  endtask

  task automatic rand_in(input bit allow_init);
    set_in(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 31)),
           allow_init && ($urandom_range(0, 149) == 0));
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_data0", {16'd0, rd_data0}, 32'd0);
    chk("rst_rd_data1", {16'd0, rd_data1}, 32'd0);
    chk("rst_rd_valid", {30'd0, rd_valid0, rd_valid1}, 32'd0);
    chk("rst_par_err", {30'd0, perr0, perr1}, 32'd0);
    chk("rst_init_busy", {30'd0, bsy0, bsy1}, 32'd3);
    q0.delete();
    q1.delete();
    m_busy = 1'b1;
    m_cnt  = 0;
    e_busy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Counts cycles with init_busy high while throwing ignored traffic at both ports
  task automatic measure_clear(input string name);
    int cnt;
    cnt = bsy0 ? 1 : 0;
    for (int i = 0; i < 64 && bsy0; i++) begin
      rand_in(1'b0);
      step();
      if (bsy0) cnt++;
    end
    chk(name, cnt, DEP);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEP; i++) begin
      set_in(0, 0, 0, 0, 1, i, 0);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    measure_clear("clear_cycles_after_reset");
    read_all();

    set_in(1, 0, 'h00AA, 3, 0, 0, 0); step();
    set_in(1, 1, 'h00BB, 3, 0, 0, 0); step();
    set_in(1, 2, 'h00CC, 3, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, i, 0);
      step();
    end
    idle();

    set_in(1, 5, 'h1234, 3, 0, 0, 0); step();
    set_in(1, 5, 'hABCD, 1, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 5, 0);      step();

    set_in(1, 7, 'h0000, 3, 0, 0, 0); step();
    set_in(1, 7, 'hFFFF, 2, 1, 7, 0); step();
    set_in(0, 0, 0, 0, 1, 7, 0);      step();
    set_in(1, 8, 'h1111, 3, 1, 9, 0); step();
    idle();

    set_in(1, 3, 'h0055, 3, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 3, 0);      step();
    set_in(1, 4, 'h0077, 3, 1, 4, 1); step();
    measure_clear("clear_cycles_after_init_req");
    read_all();

    for (int i = 0; i < 400; i++) begin
      rand_in(1'b1);
      step();
    end
    for (int i = 0; i < 64 && m_busy; i++) idle();

    set_in(0, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 5; i++) idle();
    set_in(0, 0, 0, 0, 1, 2, 0);
    do_reset();
    measure_clear("clear_cycles_after_midclear_reset");
    read_all();

`ifdef PARAM_DPR_PARITY_EN
    set_in(1, 9, 'h005A, 3, 0, 0, 0); step();
    idle();
    u_dut0.r_par_mem[9][0] = ~u_dut0.r_par_mem[9][0];
    u_dut1.r_par_mem[9][0] = ~u_dut1.r_par_mem[9][0];
    m_cor[9][0] = ~m_cor[9][0];
    set_in(0, 0, 0, 0, 1, 9, 0);  step();
    set_in(0, 0, 0, 0, 1, 20, 0); step();
    set_in(1, 9, 'h3300, 2, 1, 9, 0); step();
    set_in(0, 0, 0, 0, 1, 9, 0);  step();
`endif

    set_in(0, 0, 0, 0, 1, 20, 0); step();
    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_dpr.md
Name: param_dpr

Overview:
- Parametrised simple dual-port RAM: one write port, one independent read port, single clock.
- Adds byte-enable writes, a configurable read pipeline with a valid flag, a defined same-address collision policy, and a hardware clear sequencer that zeroes the array after reset or on request.
- Drop-in storage for buffers and line memories in the datapath.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 12, address width.
- DEPTH, 4096, number of words; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- COLL_MODE, 0, same-address collision policy: 0 = read-old, 1 = write-through.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  request a full array clear.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i controls byte i.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle pulse when rd_data carries a new result.
- init_busy  out  1  high while the clear sequence runs.
- rd_par_err  out  1  parity error, aligned with rd_valid (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, rd_par_err=0, init_busy=1.
  - Read pipeline flushed; FSM forced to INIT; clear counter=0.
  - The array itself is not reset asynchronously.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes 0 (and parity 0) to mem[cnt], then cnt++.
  - After the write of cnt=DEPTH-1, the FSM moves to READY on the next edge.
  - A full clear takes DEPTH cycles; init_busy falls on the cycle READY is entered.
  - wr_en and rd_en are ignored; no rd_valid is issued for them.
  - init_req during INIT restarts the count at 0.
- READY:
  - init_req takes priority: FSM goes to INIT with cnt=0; same-cycle wr_en and rd_en are ignored.
  - Reads accepted before init_req still complete with the data captured at acceptance.
- Write:
  - In READY with wr_en=1 and wr_addr<DEPTH, each byte i with wr_be[i]=1 is updated at the edge; other bytes are unchanged.
  - wr_be=0 means no change.
  - wr_addr>=DEPTH: write dropped.
- Read:
  - rd_en sampled high in READY at edge N produces rd_data and rd_valid=1 after edge N+RD_LAT−1, i.e. registered at edge N (RD_LAT=1) or edge N+1 (RD_LAT=2).
  - Fully pipelined: one read per cycle; back-to-back reads give back-to-back rd_valid.
  - rd_data holds its last value when no new result is output; rd_valid is 0 in those cycles.
  - rd_addr>=DEPTH returns 0, with rd_valid=1 and rd_par_err=0.
- Collision (wr_en and rd_en in the same cycle, same in-range address):
  - COLL_MODE=0: read returns the pre-write word.
  - COLL_MODE=1: read returns the merged word (enabled bytes from wr_data, other bytes old).
  - Different addresses: no interaction.
- Reset mid-operation: in-flight reads are lost with no rd_valid; the clear restarts from 0 after rst_n rises.

Optional Feature:
- Macro: PARAM_DPR_PARITY_EN.
- With the macro defined:
  - The array stores one even-parity bit per byte, written with each enabled byte.
  - On read, parity is recomputed; rd_par_err=1 in the rd_valid cycle if any byte mismatches.
  - The parity bits are exposed to the bench hierarchically for error injection.
- Without the macro: no parity storage; rd_par_err is tied to 0.

Test Plan:
- Reset and clear, DEPTH=16: release rst_n → init_busy=1 for exactly 16 cycles. Reads of all 16 addresses then return 0x00 with one rd_valid pulse each.
- Basic write/read, defaults: write 0xAA@0, 0xBB@1, 0xCC@2, then read 0,1,2 back-to-back → rd_data 0xAA, 0xBB, 0xCC on consecutive cycles with rd_valid high. Repeat with RD_LAT=2 and check the extra cycle of latency.
- Byte enables, DATA_W=16: write 0x1234@5 with be=11, then 0xABCD@5 with be=01 → read 0x12CD.
- Collision, DATA_W=16: mem[7]=0x0000; write 0xFFFF@7 with be=10 while reading 7. COLL_MODE=0 → 0x0000. COLL_MODE=1 → 0xFF00. Next read of 7 → 0xFF00 in both modes.
- init_req and reset mid-op: issue a read of addr 3 (holding 0x55), then init_req the next cycle → read completes with 0x55, then init_busy=1; a write during INIT is dropped. Assert rst_n low mid-clear → outputs 0 immediately and the clear restarts.
- Parity (macro on): write 0x5A@9, flip the stored parity bit, read 9 → rd_data 0x5A, rd_par_err=1 in the rd_valid cycle. Out-of-range read with DEPTH=16 and addr 20 → 0x00, rd_valid=1, rd_par_err=0.
